time_keeper: RTL and testbench

TIME_KEEPER -- requirements
Module: time_keeper

---
 rtl/clock_pkg.sv | 18 +
 rtl/btn_sync_edge.sv | 35 +++
 rtl/time_keeper.sv | 157 +++++++++++++++
 tb/tb_time_keeper.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared mode encoding, time limits and BCD helper for time_keeper.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } mode_t;

    localparam logic [6:0] HOUR_MAX = 7'd23;
    localparam logic [6:0] MIN_MAX  = 7'd59;
    localparam logic [6:0] SEC_MAX  = 7'd59;

    function automatic logic [6:0] bcd_val(input logic [3:0] tens, input logic [3:0] units);
        return {3'b000, tens} * 7'd10 + {3'b000, units};
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-FF synchronizer plus rising-edge detector for one button.
// A button still held when reset releases stays disarmed until seen released.
module btn_sync_edge (
    input  logic enable_clock,
    input  logic enable_reset,
    input  logic i_btn,
    output logic o_rise
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic       r_armed;
    logic [1:0] r_warm;

    always_ff @(posedge enable_clock or negedge enable_reset) begin
        if (!enable_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_warm  <= 2'b00;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_warm  <= {r_warm[0], 1'b1};
            // r_sync2 only reflects the pin once the pipeline has refilled
            r_armed <= r_armed | (r_warm[1] & ~r_sync2);
        end
    end

    assign o_rise = r_sync2 & ~r_prev & r_armed;

endmodule

// File: rtl/time_keeper.sv
// time_keeper: 24h BCD clock with RUN / SET_HOUR / SET_MIN modes driven by two buttons.
module time_keeper
    import clock_pkg::*;
(
    input  logic       enable_clock,
    input  logic       enable_reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [1:0] hour_tens,
    output logic [3:0] hour_units,
    output logic [2:0] min_tens,
    output logic [3:0] min_units,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_units,
    output logic [1:0] mode,
    output logic       blink
);

    mode_t      r_mode, w_mode_nxt;
    logic       r_blink, w_blink_nxt;
    logic [1:0] r_hour_tens, w_hour_tens_nxt;
    logic [3:0] r_hour_units, w_hour_units_nxt;
    logic [2:0] r_min_tens, w_min_tens_nxt;
    logic [3:0] r_min_units, w_min_units_nxt;
    logic [2:0] r_sec_tens, w_sec_tens_nxt;
    logic [3:0] r_sec_units, w_sec_units_nxt;

    logic       w_mode_rise;
    logic       w_inc_rise;
    logic       w_sec_wrap;
    logic       w_min_wrap;
    logic       w_hour_wrap;
    logic [3:0] w_sec_units_inc;
    logic [2:0] w_sec_tens_inc;
    logic [3:0] w_min_units_inc;
    logic [2:0] w_min_tens_inc;
    logic [3:0] w_hour_units_inc;
    logic [1:0] w_hour_tens_inc;

    btn_sync_edge u_mode_btn (
        .enable_clock (enable_clock),
        .enable_reset (enable_reset),
        .i_btn        (btn_mode),
        .o_rise       (w_mode_rise)
    );

    btn_sync_edge u_inc_btn (
        .enable_clock (enable_clock),
        .enable_reset (enable_reset),
        .i_btn        (btn_inc),
        .o_rise       (w_inc_rise)
    );

    assign w_sec_wrap  = bcd_val({1'b0, r_sec_tens}, r_sec_units) == SEC_MAX;
    assign w_min_wrap  = bcd_val({1'b0, r_min_tens}, r_min_units) == MIN_MAX;
    assign w_hour_wrap = bcd_val({2'b00, r_hour_tens}, r_hour_units) == HOUR_MAX;

    // Each field increments on its own and wraps at its limit; carries are chained in RUN only
    assign w_sec_units_inc  = (r_sec_units == 4'd9) ? 4'd0 : r_sec_units + 4'd1;
    assign w_sec_tens_inc   = w_sec_wrap ? 3'd0 : (r_sec_units == 4'd9) ? r_sec_tens + 3'd1 : r_sec_tens;
    assign w_min_units_inc  = (r_min_units == 4'd9) ? 4'd0 : r_min_units + 4'd1;
    assign w_min_tens_inc   = w_min_wrap ? 3'd0 : (r_min_units == 4'd9) ? r_min_tens + 3'd1 : r_min_tens;
    assign w_hour_units_inc = (w_hour_wrap || r_hour_units == 4'd9) ? 4'd0 : r_hour_units + 4'd1;
    assign w_hour_tens_inc  = w_hour_wrap ? 2'd0 : (r_hour_units == 4'd9) ? r_hour_tens + 2'd1 : r_hour_tens;

    always_comb begin
        w_mode_nxt       = r_mode;
        w_blink_nxt      = r_blink;
        w_hour_tens_nxt  = r_hour_tens;
        w_hour_units_nxt = r_hour_units;
        w_min_tens_nxt   = r_min_tens;
        w_min_units_nxt  = r_min_units;
        w_sec_tens_nxt   = r_sec_tens;
        w_sec_units_nxt  = r_sec_units;
        case (r_mode)
            RUN: begin
                w_blink_nxt = 1'b0;
                if (tick_1hz) begin
                    w_sec_units_nxt = w_sec_units_inc;
                    w_sec_tens_nxt  = w_sec_tens_inc;
                    if (w_sec_wrap) begin
                        w_min_units_nxt = w_min_units_inc;
                        w_min_tens_nxt  = w_min_tens_inc;
                        if (w_min_wrap) begin
                            w_hour_units_nxt = w_hour_units_inc;
                            w_hour_tens_nxt  = w_hour_tens_inc;
                        end
                    end
                end
                if (w_mode_rise) w_mode_nxt = SET_HOUR;
            end
            SET_HOUR: begin
                if (w_mode_rise) begin
                    w_mode_nxt  = SET_MIN;
                    w_blink_nxt = 1'b0;
                end else begin
                    w_blink_nxt = r_blink ^ tick_1hz;
                    if (w_inc_rise) begin
                        w_hour_units_nxt = w_hour_units_inc;
                        w_hour_tens_nxt  = w_hour_tens_inc;
                    end
                end
            end
            SET_MIN: begin
                if (w_mode_rise) begin
                    w_mode_nxt      = RUN;
                    w_blink_nxt     = 1'b0;
                    w_sec_tens_nxt  = 3'd0;
                    w_sec_units_nxt = 4'd0;
                end else begin
                    w_blink_nxt = r_blink ^ tick_1hz;
                    if (w_inc_rise) begin
                        w_min_units_nxt = w_min_units_inc;
                        w_min_tens_nxt  = w_min_tens_inc;
                    end
                end
            end
            default: begin
                w_mode_nxt  = RUN;
                w_blink_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge enable_clock or negedge enable_reset) begin
        if (!enable_reset) begin
            r_mode       <= RUN;
            r_blink      <= 1'b0;
            r_hour_tens  <= 2'd0;
            r_hour_units <= 4'd0;
            r_min_tens   <= 3'd0;
            r_min_units  <= 4'd0;
            r_sec_tens   <= 3'd0;
            r_sec_units  <= 4'd0;
        end else begin
            r_mode       <= w_mode_nxt;
            r_blink      <= w_blink_nxt;
            r_hour_tens  <= w_hour_tens_nxt;
            r_hour_units <= w_hour_units_nxt;
            r_min_tens   <= w_min_tens_nxt;
            r_min_units  <= w_min_units_nxt;
            r_sec_tens   <= w_sec_tens_nxt;
            r_sec_units  <= w_sec_units_nxt;
        end
    end

    assign hour_tens  = r_hour_tens;
    assign hour_units = r_hour_units;
    assign min_tens   = r_min_tens;
    assign min_units  = r_min_units;
    assign sec_tens   = r_sec_tens;
    assign sec_units  = r_sec_units;
    assign mode       = r_mode;
    assign blink      = r_blink;

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: randomized self-checking bench for time_keeper.
// Reference model keeps time as seconds-of-day and applies button/tick rules arithmetically.
module tb_time_keeper;

    logic       enable_clock = 1'b0;
    logic       enable_reset = 1'b0;
    logic       tick_1hz     = 1'b0;
    logic       btn_mode     = 1'b0;
    logic       btn_inc      = 1'b0;
    logic [1:0] hour_tens;
    logic [3:0] hour_units;
    logic [2:0] min_tens;
    logic [3:0] min_units;
    logic [2:0] sec_tens;
    logic [3:0] sec_units;
    logic [1:0] mode;
    logic       blink;

    int checks = 0;
    int errors = 0;
    int m_t    = 0;
    int m_md   = 0;
    bit m_bl   = 1'b0;

    time_keeper dut (
        .enable_clock (enable_clock),
        .enable_reset (enable_reset),
        .tick_1hz     (tick_1hz),
        .btn_mode     (btn_mode),
        .btn_inc      (btn_inc),
        .hour_tens    (hour_tens),
        .hour_units   (hour_units),
        .min_tens     (min_tens),
        .min_units    (min_units),
        .sec_tens     (sec_tens),
        .sec_units    (sec_units),
        .mode         (mode),
        .blink        (blink)
    );

    always #10 enable_clock = ~enable_clock;

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    function automatic logic [22:0] exp_vec();
        int h, m, s;
        h = m_t / 3600;
        m = (m_t / 60) % 60;
        s = m_t % 60;
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10), 2'(m_md), m_bl};
    endfunction

    function automatic logic [22:0] got();
        return {hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units, mode, blink};
    endfunction

    function automatic void m_reset();
        m_t  = 0;
        m_md = 0;
        m_bl = 1'b0;
    endfunction

    function automatic void m_tick();
        if (m_md == 0) m_t = (m_t + 1) % 86400;
        else m_bl = ~m_bl;
    endfunction

    function automatic void m_mode();
        if (m_md == 2) m_t = m_t - m_t % 60;
        m_md = (m_md + 1) % 3;
        m_bl = 1'b0;
    endfunction

    function automatic void m_inc();
        int h, mm;
        h  = m_t / 3600;
        mm = (m_t / 60) % 60;
        if (m_md == 1) m_t = m_t - h * 3600 + ((h + 1) % 24) * 3600;
        if (m_md == 2) m_t = m_t - mm * 60 + ((mm + 1) % 60) * 60;
    endfunction

    task automatic step();
        @(posedge enable_clock);
        #1;
    endtask

    task automatic do_reset();
        enable_reset = 1'b0;
        #2;
        m_reset();
        enable_reset = 1'b1;
        repeat (4) step();
    endtask

    task automatic tick();
        tick_1hz = 1'b1;
        step();
        tick_1hz = 1'b0;
        m_tick();
    endtask

    // Action lands on the third sampling edge; tk pulses tick on that same edge
    task automatic press(input bit bm, input bit bi, input bit tk);
        btn_mode = bm;
        btn_inc  = bi;
        step();
        step();
        tick_1hz = tk;
        step();
        tick_1hz = 1'b0;
        if (tk) m_tick();
        if (bm) m_mode();
        else if (bi) m_inc();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        logic [22:0] zero;
        zero = '0;
        do_reset();
        checks++;
        if (got() !== zero) begin
            errors++;
            $display("FAIL reset_init: got %h expected %h", got(), zero);
        end
        repeat (3) tick();
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        tick();
        enable_reset = 1'b0;
        #2;
        m_reset();
        checks++;
        if (got() !== zero) begin
            errors++;
            $display("FAIL reset_async: got %h expected %h", got(), zero);
        end
        enable_reset = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_run_ticks();
        logic [22:0] want;
        want = {2'd0, 4'd0, 3'd0, 4'd1, 3'd0, 4'd0, 2'd0, 1'b0};
        do_reset();
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) step();
            if ($urandom_range(0, 3) == 0) btn_inc = 1'b1;
            tick();
            checks++;
            if (got() !== exp_vec()) begin
                errors++;
                $display("FAIL run_tick %0d: got %h expected %h", i, got(), exp_vec());
            end
        end
        btn_inc = 1'b0;
        repeat (4) step();
        checks++;
        if (got() !== want) begin
            errors++;
            $display("FAIL run_60_ticks: got %h expected %h", got(), want);
        end
    endtask

    task automatic test_set_wrap();
        logic [22:0] zero;
        zero = '0;
        press(1'b1, 1'b0, 1'b0);
        while (m_t / 3600 != 23) press(1'b0, 1'b1, 1'b0);
        checks++;
        if (got() !== exp_vec()) begin
            errors++;
            $display("FAIL set_hour_23: got %h expected %h", got(), exp_vec());
        end
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if (got() !== exp_vec()) begin
            errors++;
            $display("FAIL hour_wrap: got %h expected %h", got(), exp_vec());
        end
        repeat (23) press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        while ((m_t / 60) % 60 != 59) press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if (got() !== exp_vec()) begin
            errors++;
            $display("FAIL min_wrap: got %h expected %h", got(), exp_vec());
        end
        repeat (59) press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if (got() !== exp_vec()) begin
            errors++;
            $display("FAIL exit_clear_sec: got %h expected %h", got(), exp_vec());
        end
        for (int i = 0; i < 60; i++) begin
            tick();
            checks++;
            if (got() !== exp_vec()) begin
                errors++;
                $display("FAIL wrap_tick %0d: got %h expected %h", i, got(), exp_vec());
            end
        end
        checks++;
        if (got() !== zero) begin
            errors++;
            $display("FAIL day_wrap: got %h expected %h", got(), zero);
        end
    endtask

    task automatic test_blink_freeze();
        int  toggles;
        bit  prev;
        repeat (7) tick();
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if (got() !== exp_vec()) begin
            errors++;
            $display("FAIL enter_set_hour: got %h expected %h", got(), exp_vec());
        end
        toggles = 0;
        prev    = blink;
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(1, 3)) step();
            tick();
            checks++;
            if (got() !== exp_vec()) begin
                errors++;
                $display("FAIL freeze_tick %0d: got %h expected %h", i, got(), exp_vec());
            end
            if (blink !== prev) toggles++;
            prev = blink;
        end
        checks++;
        if (toggles != 5) begin
            errors++;
            $display("FAIL blink_toggles: got %0d expected 5", toggles);
        end
        btn_inc = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (i == 2) m_inc();
        end
        btn_inc = 1'b0;
        repeat (3) step();
        checks++;
        if (got() !== exp_vec()) begin
            errors++;
            $display("FAIL hold_inc: got %h expected %h", got(), exp_vec());
        end
        press(1'b0, 1'b1, 1'b1);
        checks++;
        if (got() !== exp_vec()) begin
            errors++;
            $display("FAIL tick_and_inc: got %h expected %h", got(), exp_vec());
        end
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        checks++;
        if (got() !== exp_vec()) begin
            errors++;
            $display("FAIL mode_and_inc: got %h expected %h", got(), exp_vec());
        end
        press(1'b1, 1'b0, 1'b1);
        checks++;
        if (got() !== exp_vec()) begin
            errors++;
            $display("FAIL tick_and_mode_run: got %h expected %h", got(), exp_vec());
        end
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_held();
        logic [22:0] zero;
        zero = '0;
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        btn_mode = 1'b1;
        step();
        enable_reset = 1'b0;
        #2;
        m_reset();
        checks++;
        if (got() !== zero) begin
            errors++;
            $display("FAIL reset_in_set: got %h expected %h", got(), zero);
        end
        enable_reset = 1'b1;
        repeat (20) step();
        checks++;
        if (got() !== exp_vec()) begin
            errors++;
            $display("FAIL held_no_action: got %h expected %h", got(), exp_vec());
        end
        btn_mode = 1'b0;
        repeat (5) step();
        press(1'b1, 1'b0, 1'b0);
        checks++;
        if (got() !== exp_vec()) begin
            errors++;
            $display("FAIL repress: got %h expected %h", got(), exp_vec());
        end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                repeat ($urandom_range(0, 2)) step();
                tick();
            end else begin
                press(r == 5 || r == 6 || r == 9, r == 7 || r == 8 || r == 9, 1'($urandom_range(0, 1)));
            end
            checks++;
            if (got() !== exp_vec()) begin
                errors++;
                $display("FAIL random %0d: got %h expected %h", i, got(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_ticks();
        test_set_wrap();
        test_blink_freeze();
        test_reset_held();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
